ahb_arbiter_rr: RTL
===================

# ahb_arbiter_rr

Parametrised AHB bus arbiter for NUM_MASTERS masters with round-robin grant, default-master parking, locked-transfer support and fixed-length burst hold. It sits between the master_if agents and the shared address/control mux. It drives the one-hot hgrant vector and the hmaster/hmastlock signals sampled by every slave. It generalises the two-master arbitration assumed so far to any master count from 2 to 16.

## Interface
- NUM_MASTERS, 4: number of requesting masters, legal range 2..16.
- DEFAULT_MASTER, 0: index granted when no master requests; must be < NUM_MASTERS.
- hclk  input  1  bus clock; all state updates on the rising edge.
- hreset  input  1  reset, asynchronous, active-low.
- hbusreq  input  NUM_MASTERS  per-master bus request.
- hlock  input  NUM_MASTERS  per-master lock request.
- htrans  input  2  transfer type of the current address-bus owner (muxed).
- hburst  input  3  burst type of the current owner.
- hready  input  1  shared transfer-done.
- hresp  input  2  shared slave response.
- hgrant  output  NUM_MASTERS  one-hot grant, registered.
- hmaster  output  4  index of the address-bus owner, registered.
- hmastlock  output  1  current owner's transfer is locked, registered.

## Operation
- Reset values: hgrant = one-hot bit DEFAULT_MASTER; hmaster = DEFAULT_MASTER; hmastlock = 0; beat counter = 0; last_grant = DEFAULT_MASTER.
- Arbitration point: a rising edge with hready=1 and hold=0. At any other edge hgrant is unchanged.
- hold = locked OR burst_hold:
  - locked = hlock[granted index].
  - burst_hold = the next beat-counter value is nonzero (see below).
- Round-robin selection at each arbitration point:
  - Scan hbusreq starting at (last_grant+1) mod NUM_MASTERS, wrapping around.
  - The first requester found wins, and last_grant becomes the winner.
  - With no requester, grant DEFAULT_MASTER and leave last_grant unchanged.
  - A sole requester keeps the grant indefinitely.
- Ownership handover: on each edge with hready=1, hmaster <= index of hgrant and hmastlock <= hlock[index of hgrant].
- Beat counter (4 bits), updated only on edges with hready=1:
  - htrans=NONSEQ with hburst INCR4/WRAP4 loads 3, INCR8/WRAP8 loads 7, INCR16/WRAP16 loads 15.
  - htrans=NONSEQ with SINGLE or INCR loads 0.
  - htrans=SEQ decrements the counter, saturating at 0.
  - htrans=BUSY holds the counter.
  - htrans=IDLE clears the counter.
- Early termination: hresp in {ERROR, RETRY, SPLIT} while hready=0 clears the counter, and hold drops on the following hready=1 edge.
- Simultaneous events:
  - If reset is asserted at any time, all state returns to reset values immediately, regardless of clock.
  - hbusreq withdrawn mid-burst does not release the grant until the burst ends or is terminated.

## Timing
- Grant latency: the request is sampled at an arbitration edge and hgrant is visible after that edge, giving 1 cycle.
- hmaster changes on the first hready=1 edge after hgrant changes, giving at least 1 further cycle. Wait states (hready=0) extend this.
- Burst hold: the arbitration point is the edge that accepts the last beat's address. For INCR4, that is the edge with the counter going 1 -> 0.
- Locked sequences: the grant is held for every cycle hlock of the owner stays high, plus the first edge after it falls. Arbitration occurs on that edge.
- No combinational path exists from any input to any output.

## Configuration
- AHB_ARB_BURST_HOLD_EN defined: the beat counter and burst_hold are implemented as above.
- AHB_ARB_BURST_HOLD_EN undefined: the counter is removed and burst_hold = 0. Arbitration then occurs on every hready=1 edge not blocked by lock, so fixed bursts may be interrupted (the master must rebuild the burst as INCR).

## Test plan
- Reset: hold hreset=0 for 3 cycles with NUM_MASTERS=4 -> hgrant=4'b0001, hmaster=0, hmastlock=0, including mid-cycle assertion during an active burst.
- Rotation: hbusreq=4'b1111 with single transfers and hready=1 -> grant sequence 1,2,3,0,1 (last_grant starts at 0); each hmaster follows its hgrant one cycle later.
- Burst hold: master 2 issues INCR8 while master 3 requests -> hgrant stays on 2 through 8 beats, moves to 3 on the edge accepting beat 8, and two wait states mid-burst extend the hold by 2 cycles.
- Lock: master 1 asserts hlock for 5 transfers while others request -> hgrant is fixed on 1 and hmastlock=1 for those transfers; grant moves one edge after hlock falls.
- Termination: master 0 issues WRAP16 and receives a two-cycle RETRY at beat 4 -> counter clears, and the grant moves to the next requester at the second RETRY cycle.
- Parking: hbusreq=0 after traffic -> hgrant = DEFAULT_MASTER; with AHB_ARB_BURST_HOLD_EN undefined, an INCR4 is interrupted after beat 1 when another master requests.

Source files
------------

// File: rtl/ahb_arbiter_rr.sv
// Round-robin AHB bus arbiter for 2..16 masters, with default-master parking, lock hold and fixed-burst hold.
// Latency: hgrant updates on the arbitration edge; hmaster/hmastlock follow on the next hready=1 edge. All outputs registered.
// Backpressure: hready=0 freezes grant and ownership; hlock or an unfinished fixed burst (AHB_ARB_BURST_HOLD_EN) blocks re-arbitration.
module ahb_arbiter_rr #(
  parameter int NUM_MASTERS    = 4,
  parameter int DEFAULT_MASTER = 0
) (
  input  logic                   hclk,
  input  logic                   hreset,
  input  logic [NUM_MASTERS-1:0] hbusreq,
  input  logic [NUM_MASTERS-1:0] hlock,
  input  logic [1:0]             htrans,
  input  logic [2:0]             hburst,
  input  logic                   hready,
  input  logic [1:0]             hresp,
  output logic [NUM_MASTERS-1:0] hgrant,
  output logic [3:0]             hmaster,
  output logic                   hmastlock
);

  // AHB transfer-type encodings
  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_BUSY   = 2'b01;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] TRANS_SEQ    = 2'b11;

  // AHB burst encodings
  localparam logic [2:0] BURST_SINGLE = 3'b000;
  localparam logic [2:0] BURST_INCR   = 3'b001;
  localparam logic [2:0] BURST_WRAP4  = 3'b010;
  localparam logic [2:0] BURST_INCR4  = 3'b011;
  localparam logic [2:0] BURST_WRAP8  = 3'b100;
  localparam logic [2:0] BURST_INCR8  = 3'b101;
  localparam logic [2:0] BURST_WRAP16 = 3'b110;
  localparam logic [2:0] BURST_INCR16 = 3'b111;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  localparam logic [3:0]             DEF_IDX    = 4'(DEFAULT_MASTER);
  localparam logic [NUM_MASTERS-1:0] DEF_ONEHOT = NUM_MASTERS'(1) << DEFAULT_MASTER;

  logic [3:0]             grant_idx;
  logic                   locked;
  logic                   burst_hold;
  logic                   hold;
  logic [3:0]             last_grant;
  logic                   any_req;
  logic [3:0]             win_idx;
  logic [NUM_MASTERS-1:0] win_onehot;
  logic                   hi_found;
  logic [3:0]             hi_idx;
  logic [3:0]             lo_idx;

  // Decode the one-hot grant into an index and pick up the owner's lock request.
  always_comb begin
    grant_idx = 4'd0;
    locked    = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (hgrant[i]) begin
        grant_idx = 4'(i);
        locked    = locked | hlock[i];
      end
    end
  end

  // Round-robin pick: lowest requester above last_grant, else lowest requester overall (wrap).
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = 4'd0;
    any_req  = 1'b0;
    lo_idx   = 4'd0;
    for (int j = 0; j < NUM_MASTERS; j++) begin
      if (hbusreq[j]) begin
        if (!hi_found && (4'(j) > last_grant)) begin
          hi_found = 1'b1;
          hi_idx   = 4'(j);
        end
        if (!any_req) begin
          any_req = 1'b1;
          lo_idx  = 4'(j);
        end
      end
    end
    win_idx = hi_found ? hi_idx : lo_idx;
  end

  // One-hot encode the round-robin winner.
  always_comb begin
    win_onehot = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      win_onehot[i] = (4'(i) == win_idx);
    end
  end

`ifdef AHB_ARB_BURST_HOLD_EN
  logic [3:0] beat_cnt;
  logic [3:0] beat_nxt;

  // Remaining-beat count of the owner's fixed burst; a retry/split/error during a wait state abandons the burst.
  always_comb begin
    beat_nxt = beat_cnt;
    if (hready) begin
      case (htrans)
        TRANS_NONSEQ: begin
          case (hburst)
            BURST_WRAP4,  BURST_INCR4:  beat_nxt = 4'd3;
            BURST_WRAP8,  BURST_INCR8:  beat_nxt = 4'd7;
            BURST_WRAP16, BURST_INCR16: beat_nxt = 4'd15;
            BURST_SINGLE, BURST_INCR:   beat_nxt = 4'd0;
            default:                    beat_nxt = 4'd0;
          endcase
        end
        TRANS_SEQ:  beat_nxt = (beat_cnt == 4'd0) ? 4'd0 : beat_cnt - 4'd1;
        TRANS_BUSY: beat_nxt = beat_cnt;
        TRANS_IDLE: beat_nxt = 4'd0;
        default:    beat_nxt = 4'd0;
      endcase
    end else if (hresp != RESP_OKAY) begin
      beat_nxt = 4'd0;
    end
  end

  // The arbitration point of a fixed burst is the edge whose next count reaches zero.
  assign burst_hold = (beat_nxt != 4'd0);

  // Beat counter register.
  always_ff @(posedge hclk or negedge hreset) begin
    if (!hreset) begin
      beat_cnt <= 4'd0;
    end else begin
      beat_cnt <= beat_nxt;
    end
  end
`else
  // Without burst tracking the transfer-type, burst and response inputs are not needed.
  logic unused_burst_inputs;
  assign unused_burst_inputs = ^{htrans, hburst, hresp};
  assign burst_hold = 1'b0;
`endif

  assign hold = locked | burst_hold;

  // Grant, ownership and rotation pointer: advance only on hready=1 edges; re-arbitrate when nothing holds the bus.
  always_ff @(posedge hclk or negedge hreset) begin
    if (!hreset) begin
      hgrant     <= DEF_ONEHOT;
      hmaster    <= DEF_IDX;
      hmastlock  <= 1'b0;
      last_grant <= DEF_IDX;
    end else if (hready) begin
      hmaster   <= grant_idx;
      hmastlock <= locked;
      if (!hold) begin
        if (any_req) begin
          hgrant     <= win_onehot;
          last_grant <= win_idx;
        end else begin
          hgrant <= DEF_ONEHOT;
        end
      end
    end
  end

endmodule
